// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T-step control unit for the 32-bit bus datapath
module control_sequencer #(
   parameter logic [4:0] ALU_INC = 5'b11111,
   parameter logic [4:0] ALU_ADD = 5'b00011,
   parameter logic [4:0] ALU_MUL = 5'b01111
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] IR,
   input  logic        mem_rdy,
   output logic [4:0]  bus_sel,
   output logic [15:0] reg_in,
   output logic        PC_in,
   output logic        IR_in,
   output logic        Y_in,
   output logic        Z_in,
   output logic        HI_in,
   output logic        LO_in,
   output logic        MAR_in,
   output logic        MDR_in,
   output logic [4:0]  ALU_select,
   output logic        mem_read,
   output logic        mem_write,
   output logic        halted,
   output logic [3:0]  step
);
   typedef enum logic [3:0] {
      T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4,
      T5 = 4'd5, T6 = 4'd6, T7 = 4'd7, T8 = 4'd8, HALT = 4'd15
   } state_t;
   localparam logic [4:0] SEL_HI  = 5'd16;
   localparam logic [4:0] SEL_LO  = 5'd17;
   localparam logic [4:0] SEL_ZHI = 5'd18;
   localparam logic [4:0] SEL_ZLO = 5'd19;
   localparam logic [4:0] SEL_PC  = 5'd20;
   localparam logic [4:0] SEL_MDR = 5'd21;
   localparam logic [4:0] SEL_C   = 5'd23;
   state_t state_q, state_d;
   logic [4:0] op;
   logic [3:0] ra, rb, rc;
   logic [15:0] ra_hot;
   logic is_alu, is_imm, is_ld, is_st, is_mul, is_mfhi, is_mflo, is_halt, is_ex;
   logic unused_ir;
   assign op = IR[31:27];
   assign ra = IR[26:23];
   assign rb = IR[22:19];
   assign rc = IR[18:15];
   assign unused_ir = ^IR[14:0];
   assign ra_hot = 16'd1 << ra;
   assign is_alu = op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110};
   assign is_imm = op inside {5'b01000, 5'b00001};
   assign is_ld = op == 5'b00000;
   assign is_st = op == 5'b00010;
   assign is_mul = op == 5'b01111;
   assign is_mfhi = op == 5'b10000;
   assign is_mflo = op == 5'b10001;
   assign is_halt = op == 5'b11011;
   assign is_ex = is_alu | is_imm | is_ld | is_st | is_mul;
   // next T-step: fetch, opcode-dependent execute length, memory waits
   always_comb begin
      state_d = state_q;
      case (state_q)
         T0: state_d = T1;
         T1: state_d = T2;
         T2: state_d = mem_rdy ? T3 : T2;
         T3: state_d = T4;
         T4: state_d = is_halt ? HALT : is_ex ? T5 : T0;
         T5: state_d = T6;
         T6: state_d = (is_ld | is_st | is_mul) ? T7 : T0;
         T7: state_d = is_ld ? (mem_rdy ? T8 : T7) : is_st ? T8 : T0;
         T8: state_d = (is_st & ~mem_rdy) ? T8 : T0;
         HALT: state_d = HALT;
         default: state_d = T0;
      endcase
   end
   // step register; clr low restarts at T0 and is the only way out of HALT
   always_ff @(posedge clk) state_q <= clr ? state_d : T0;
   // strobe decode from (step, IR); everything forced low while clr is low
   always_comb begin
      bus_sel = '0;
      reg_in = '0;
      PC_in = 1'b0;
      IR_in = 1'b0;
      Y_in = 1'b0;
      Z_in = 1'b0;
      HI_in = 1'b0;
      LO_in = 1'b0;
      MAR_in = 1'b0;
      MDR_in = 1'b0;
      ALU_select = '0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      halted = 1'b0;
      step = '0;
      if (clr) begin
         step = state_q;
         case (state_q)
            T0: begin
               bus_sel = SEL_PC;
               MAR_in = 1'b1;
               ALU_select = ALU_INC;
               Z_in = 1'b1;
            end
            T1: begin
               bus_sel = SEL_ZLO;
               PC_in = 1'b1;
            end
            T2: begin
               mem_read = 1'b1;
               MDR_in = mem_rdy;
            end
            T3: begin
               bus_sel = SEL_MDR;
               IR_in = 1'b1;
            end
            T4: begin
               bus_sel = is_mul ? {1'b0, ra} : is_mfhi ? SEL_HI : is_mflo ? SEL_LO : is_ex ? {1'b0, rb} : '0;
               Y_in = is_ex;
               reg_in = (is_mfhi | is_mflo) ? ra_hot : '0;
            end
            T5: begin
               bus_sel = is_alu ? {1'b0, rc} : is_mul ? {1'b0, rb} : is_ex ? SEL_C : '0;
               ALU_select = is_alu ? op : is_mul ? ALU_MUL : is_ex ? ALU_ADD : '0;
               Z_in = is_ex;
            end
            T6: begin
               bus_sel = is_ex ? SEL_ZLO : '0;
               reg_in = (is_alu | is_imm) ? ra_hot : '0;
               MAR_in = is_ld | is_st;
               LO_in = is_mul;
            end
            T7: begin
               bus_sel = is_st ? {1'b0, ra} : is_mul ? SEL_ZHI : '0;
               mem_read = is_ld;
               MDR_in = is_st | (is_ld & mem_rdy);
               HI_in = is_mul;
            end
            T8: begin
               bus_sel = is_ld ? SEL_MDR : '0;
               reg_in = is_ld ? ra_hot : '0;
               mem_write = is_st;
            end
            HALT: halted = 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and random checking of control_sequencer against a per-instruction step-list model
module tb_control_sequencer;
   logic clk = 1'b0;
   logic clr, mem_rdy;
   logic [31:0] ir;
   logic [4:0] bus_sel, alu_select;
   logic [15:0] reg_in;
   logic pc_in, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in;
   logic mem_read, mem_write, halted;
   logic [3:0] step;
   control_sequencer dut (
      .clk(clk), .clr(clr), .IR(ir), .mem_rdy(mem_rdy),
      .bus_sel(bus_sel), .reg_in(reg_in),
      .PC_in(pc_in), .IR_in(ir_in), .Y_in(y_in), .Z_in(z_in),
      .HI_in(hi_in), .LO_in(lo_in), .MAR_in(mar_in), .MDR_in(mdr_in),
      .ALU_select(alu_select), .mem_read(mem_read), .mem_write(mem_write),
      .halted(halted), .step(step)
   );
   always #5 clk = ~clk;
   localparam int S_PC = 8'h80, S_IR = 8'h40, S_Y = 8'h20, S_Z = 8'h10;
   localparam int S_HI = 8'h08, S_LO = 8'h04, S_MAR = 8'h02, S_MDR = 8'h01;
   typedef struct packed {
      logic [3:0]  st;
      logic [4:0]  bus;
      logic [15:0] ri;
      logic [7:0]  sb;
      logic [4:0]  alu;
      logic        rd;
      logic        wr;
      logic        wt;
   } uop_t;
   int total = 0, bad = 0;
   uop_t prog[$];
   uop_t cu;
   logic [7:0] cur_sb;
   int k = 0;
   bit armed = 0, m_halt = 0, hlt_pend = 0;
   logic [40:0] act;
   assign act = {bus_sel, reg_in, pc_in, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in,
                 alu_select, mem_read, mem_write, halted, step};
   function automatic logic [40:0] v(int bus, int ri, int sb, int alu, int rd, int wr, int h, int st);
      return {bus[4:0], ri[15:0], sb[7:0], alu[4:0], rd[0], wr[0], h[0], st[3:0]};
   endfunction
   function automatic uop_t u(int st, int bus, int ri, int sb, int alu, int rd, int wr, int wt);
      uop_t x;
      x.st = st[3:0];
      x.bus = bus[4:0];
      x.ri = ri[15:0];
      x.sb = sb[7:0];
      x.alu = alu[4:0];
      x.rd = rd[0];
      x.wr = wr[0];
      x.wt = wt[0];
      return x;
   endfunction
   function automatic logic [31:0] mk(int op, int a, int b, int c, int imm);
      return {op[4:0], a[3:0], b[3:0], c[3:0], imm[14:0]};
   endfunction
   task automatic cmp(string n, logic [40:0] a, logic [40:0] e);
      logic [40:0] am;
      am = e[4] ? {a[40:4], 4'd0} : a;
      total++;
      if (am !== e) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", n, $time, am, e);
      end
   endtask
   function automatic void load_fetch();
      prog.delete();
      prog.push_back(u(0, 20, 0, S_MAR | S_Z, 31, 0, 0, 0));
      prog.push_back(u(1, 19, 0, S_PC, 0, 0, 0, 0));
      prog.push_back(u(2, 0, 0, 0, 0, 1, 0, 1));
      prog.push_back(u(3, 21, 0, S_IR, 0, 0, 0, 0));
   endfunction
   function automatic void build(logic [31:0] x);
      int op = int'(x[31:27]);
      int a = int'(x[26:23]);
      int b = int'(x[22:19]);
      int c = int'(x[18:15]);
      int ra = 1 << a;
      hlt_pend = (op == 27);
      if (op inside {1, 3, 4, 5, 6, 8}) begin
         prog.push_back(u(4, b, 0, S_Y, 0, 0, 0, 0));
         prog.push_back((op inside {1, 8}) ? u(5, 23, 0, S_Z, 3, 0, 0, 0) : u(5, c, 0, S_Z, op, 0, 0, 0));
         prog.push_back(u(6, 19, ra, 0, 0, 0, 0, 0));
      end else if (op inside {0, 2}) begin
         prog.push_back(u(4, b, 0, S_Y, 0, 0, 0, 0));
         prog.push_back(u(5, 23, 0, S_Z, 3, 0, 0, 0));
         prog.push_back(u(6, 19, 0, S_MAR, 0, 0, 0, 0));
         if (op == 0) begin
            prog.push_back(u(7, 0, 0, 0, 0, 1, 0, 1));
            prog.push_back(u(8, 21, ra, 0, 0, 0, 0, 0));
         end else begin
            prog.push_back(u(7, a, 0, S_MDR, 0, 0, 0, 0));
            prog.push_back(u(8, 0, 0, 0, 0, 0, 1, 1));
         end
      end else if (op == 15) begin
         prog.push_back(u(4, a, 0, S_Y, 0, 0, 0, 0));
         prog.push_back(u(5, b, 0, S_Z, 15, 0, 0, 0));
         prog.push_back(u(6, 19, 0, S_LO, 0, 0, 0, 0));
         prog.push_back(u(7, 18, 0, S_HI, 0, 0, 0, 0));
      end else if (op == 16) prog.push_back(u(4, 16, ra, 0, 0, 0, 0, 0));
      else if (op == 17) prog.push_back(u(4, 17, ra, 0, 0, 0, 0, 0));
      else prog.push_back(u(4, 0, 0, 0, 0, 0, 0, 0));
   endfunction
   // model: compare this cycle's outputs, then advance to what the next edge produces
   always @(negedge clk) begin
      if (!clr) begin
         cmp("reset", act, '0);
         armed = 1;
         m_halt = 0;
         hlt_pend = 0;
         k = 0;
         load_fetch();
      end else if (armed) begin
         if (m_halt) cmp("halted", act, v(0, 0, 0, 0, 0, 0, 1, 0));
         else begin
            if (k == prog.size()) build(ir);
            cu = prog[k];
            cur_sb = cu.sb | ((cu.wt && cu.rd && mem_rdy) ? 8'(S_MDR) : 8'h00);
            cmp($sformatf("model_T%0d", cu.st), act, {cu.bus, cu.ri, cur_sb, cu.alu, cu.rd, cu.wr, 1'b0, cu.st});
            if (!(cu.wt && !mem_rdy)) k++;
            if (k > 4 && k == prog.size()) begin
               m_halt = hlt_pend;
               k = 0;
               load_fetch();
            end
         end
      end
   end
   task automatic step_chk(string n, logic [40:0] e);
      @(negedge clk);
      cmp(n, act, e);
      @(posedge clk);
      #1;
   endtask
   task automatic run(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   function automatic logic [31:0] rand_ir();
      int ops[13] = '{0, 1, 2, 3, 4, 5, 6, 8, 15, 16, 17, 26, 27};
      int i = int'($urandom_range(13));
      int op = (i == 13) ? int'($urandom_range(31)) : ops[i];
      return {op[4:0], 27'($urandom)};
   endfunction
   logic [40:0] t0v;
   initial begin
      t0v = v(20, 0, S_MAR | S_Z, 31, 0, 0, 0, 0);
      clr = 1'b0;
      mem_rdy = 1'b1;
      ir = mk(3, 5, 2, 4, 0);
      step_chk("rst_a", '0);
      step_chk("rst_b", '0);
      clr = 1'b1;
      step_chk("fetch_t0", t0v);
      mem_rdy = 1'b0;
      step_chk("fetch_t1", v(19, 0, S_PC, 0, 0, 0, 0, 1));
      repeat (3) step_chk("t2_wait", v(0, 0, 0, 0, 1, 0, 0, 2));
      mem_rdy = 1'b1;
      step_chk("t2_rdy", v(0, 0, S_MDR, 0, 1, 0, 0, 2));
      step_chk("fetch_t3", v(21, 0, S_IR, 0, 0, 0, 0, 3));
      step_chk("add_t4", v(2, 0, S_Y, 0, 0, 0, 0, 4));
      step_chk("add_t5", v(4, 0, S_Z, 3, 0, 0, 0, 5));
      step_chk("add_t6", v(19, 16'h0020, 0, 0, 0, 0, 0, 6));
      ir = 32'h10900055;
      step_chk("add_next_t0", t0v);
      run(3);
      step_chk("st_t4", v(2, 0, S_Y, 0, 0, 0, 0, 4));
      step_chk("st_t5", v(23, 0, S_Z, 3, 0, 0, 0, 5));
      step_chk("st_t6", v(19, 0, S_MAR, 0, 0, 0, 0, 6));
      step_chk("st_t7", v(1, 0, S_MDR, 0, 0, 0, 0, 7));
      mem_rdy = 1'b0;
      repeat (2) step_chk("st_t8_wait", v(0, 0, 0, 0, 0, 1, 0, 8));
      mem_rdy = 1'b1;
      step_chk("st_t8_rdy", v(0, 0, 0, 0, 0, 1, 0, 8));
      ir = mk(15, 3, 4, 0, 0);
      step_chk("st_next_t0", t0v);
      run(3);
      step_chk("mul_t4", v(3, 0, S_Y, 0, 0, 0, 0, 4));
      step_chk("mul_t5", v(4, 0, S_Z, 15, 0, 0, 0, 5));
      step_chk("mul_t6", v(19, 0, S_LO, 0, 0, 0, 0, 6));
      step_chk("mul_t7", v(18, 0, S_HI, 0, 0, 0, 0, 7));
      ir = mk(16, 6, 0, 0, 0);
      run(4);
      step_chk("mfhi_t4", v(16, 16'h0040, 0, 0, 0, 0, 0, 4));
      ir = 32'hD8000000;
      run(4);
      step_chk("halt_t4", v(0, 0, 0, 0, 0, 0, 0, 4));
      for (int i = 0; i < 10; i++) begin
         mem_rdy = i[0];
         step_chk("halt_hold", v(0, 0, 0, 0, 0, 0, 1, 0));
      end
      clr = 1'b0;
      step_chk("halt_clr", '0);
      clr = 1'b1;
      mem_rdy = 1'b1;
      step_chk("restart_t0", t0v);
      for (int i = 0; i < 3000; i++) begin
         clr = ($urandom_range(99) >= 2);
         mem_rdy = ($urandom_range(2) != 0);
         if (k == 0 && !m_halt) ir = rand_ir();
         run(1);
      end
      run(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
